axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file with NUM_REGS word registers, byte-strobe writes and independent AW/W acceptance.
- Supports per-register read-only mapping to hardware status inputs and returns SLVERR on out-of-range or read-only writes.
- Sits behind the AXI interconnect as the control/status block for pipeline stages; drives register contents and write pulses to the datapath.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; 32 or 64.
- ADDR_WIDTH, 6, byte address width.
- NUM_REGS, 8, number of word registers; 1..2**(ADDR_WIDTH-ADDRLSB).
- RO_MASK, 0, NUM_REGS-bit mask; bit i set means register i is read-only and reads return ro_data_i slice i.
- RESET_VALUE, 0, DATA_WIDTH reset value of every RW register.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-high.
- aw_addr  in  ADDR_WIDTH  write address.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address ready.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  DATA_WIDTH/8  byte strobes.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data ready.
- b_resp  out  2  write response.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response ready.
- ar_addr  in  ADDR_WIDTH  read address.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address ready.
- r_data  out  DATA_WIDTH  read data.
- r_resp  out  2  read response.
- r_valid  out  1  read valid.
- r_ready  in  1  read ready.
- ro_data_i  in  NUM_REGS*DATA_WIDTH  status values for RO registers; slice i used when RO_MASK[i] is set.
- regs_o  out  NUM_REGS*DATA_WIDTH  current RW register contents; RO slices drive 0.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per register on a committed OKAY write.

Behaviour:
- Reset: rstn_i high asynchronously clears aw_ready, w_ready, b_valid and r_valid to 0, b_resp, r_resp and r_data to 0, and wr_pulse_o to 0.
  - Sets RW registers to RESET_VALUE and drops any held AW/W.
  - In the first cycle after release, aw_ready=w_ready=ar_ready=1.
- Decode: ADDRLSB=$clog2(DATA_WIDTH/8); idx=addr[ADDR_WIDTH-1:ADDRLSB]. Low ADDRLSB bits are ignored. idx>=NUM_REGS means out of range.
- Write channel: AW and W are captured independently into holding registers with flags aw_held and w_held.
  - aw_ready=!aw_held and w_ready=!w_held, both from registered flags only.
  - Commit occurs in the cycle where aw_held && w_held && (!b_valid || b_ready).
  - At the commit edge: strobed byte write (bytes with w_strb=0 unchanged), b_valid<=1, b_resp set, both flags cleared, wr_pulse_o[idx]<=1 for exactly one cycle.
  - Latency: AW+W accepted together at edge N gives b_valid high after edge N+1. AW and W arriving in any order/cycles are paired in order.
- Write response: b_resp=00 OKAY on an in-range RW write. b_resp=10 SLVERR on out-of-range or RO_MASK[idx] write; no register change and no pulse in that case. b_valid and b_resp are held until b_ready.
- Read channel: ar_ready=!r_valid. On handshake at edge N, r_valid<=1 and r_data/r_resp are registered at that edge and visible in cycle N+1.
  - r_data is the RW register value, or the ro_data_i slice sampled at the handshake edge. Out of range gives r_data=0 and r_resp=10.
  - r_valid, r_data and r_resp are held stable until r_ready; r_valid then clears at the next edge.
  - Throughput: one read per 2 cycles.
- Simultaneous read handshake and write commit to the same register: the read returns the pre-write value.
- Back-pressure: with b_valid=1 and b_ready=0, a complete AW+W pair stays held, and aw_ready=w_ready=0 until commit.
- Reset mid-transaction aborts it; no b or r response is issued for it.

Test Plan:
- Reset, then AW(0x04)+W(0xDEADBEEF, strb 0xF) together with b_ready=1 -> b_valid after 2 edges, b_resp=00, regs_o[1]=0xDEADBEEF, wr_pulse_o[1] high 1 cycle; AR 0x04 -> r_data=0xDEADBEEF, r_resp=00.
- W(0x000000AA, strb 0x1) 3 cycles before AW(0x04) onto reg1=0x11223344 -> reg1=0x112233AA, single b response OKAY.
- Write 0x3C, above range for NUM_REGS=8 -> b_resp=10, no regs change, no pulse; AR 0x3C -> r_data=0, r_resp=10.
- RO_MASK=0x01, ro_data_i[0]=0xCAFE0001: write addr 0 -> SLVERR; read addr 0 -> 0xCAFE0001 OKAY.
- b_ready=0 for 5 cycles after first write with second AW+W presented -> aw_ready=w_ready=0 while held; second commit occurs in cycle b_ready rises; b_valid stays 1 across both responses.
- Assert rstn_i while r_valid=1 and an AW is held -> r_valid=0 and b_valid=0 immediately, registers return to RESET_VALUE, no stale response after release.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, byte-strobe writes,
// read-only status mapping and SLVERR on out-of-range or read-only writes.
module axi_lite_regfile #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     ADDR_WIDTH  = 6,
  parameter int                     NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDRLSB    = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - ADDRLSB;

  function automatic logic [DATA_WIDTH-1:0] strb_merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                  aw_held_r, w_held_r;
  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [STRB_WIDTH-1:0] w_strb_r;
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

  logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic                  aw_held_nxt_s, w_held_nxt_s;
  logic [NUM_REGS-1:0]   wsel_s, rsel_s;
  logic                  w_ok_s, r_ok_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  assign ar_ready = ~r_valid;
  assign aw_hs_s  = aw_valid & aw_ready;
  assign w_hs_s   = w_valid & w_ready;
  assign ar_hs_s  = ar_valid & ar_ready;
  assign commit_s = aw_held_r & w_held_r & (~b_valid | b_ready);

  // Address decode to one-hot selects and read-data mux; no select means out of range
  always_comb begin
    wsel_s  = '0;
    rsel_s  = '0;
    rdata_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel_s[i] = (aw_addr_r[ADDR_WIDTH-1:ADDRLSB] == IDX_WIDTH'(i));
      rsel_s[i] = (ar_addr[ADDR_WIDTH-1:ADDRLSB] == IDX_WIDTH'(i));
      if (rsel_s[i]) begin
        rdata_s = RO_MASK[i] ? ro_data_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i];
      end else begin
        rdata_s = rdata_s;
      end
    end
    w_ok_s = |(wsel_s & ~RO_MASK);
    r_ok_s = |rsel_s;
  end

  // Holding-flag next state; a commit and a new capture never coincide since ready = !held
  always_comb begin
    if (commit_s) begin
      aw_held_nxt_s = 1'b0;
      w_held_nxt_s  = 1'b0;
    end else begin
      aw_held_nxt_s = aw_held_r | aw_hs_s;
      w_held_nxt_s  = w_held_r | w_hs_s;
    end
  end

  // Write channel: AW/W capture, commit, response and register storage
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_ready   <= 1'b0;
      w_ready    <= 1'b0;
      aw_addr_r  <= '0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      b_valid    <= 1'b0;
      b_resp     <= 2'b00;
      wr_pulse_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
      end
    end else begin
      aw_held_r  <= aw_held_nxt_s;
      w_held_r   <= w_held_nxt_s;
      aw_ready   <= ~aw_held_nxt_s;
      w_ready    <= ~w_held_nxt_s;
      wr_pulse_o <= '0;
      if (aw_hs_s) begin
        aw_addr_r <= aw_addr;
      end
      if (w_hs_s) begin
        w_data_r <= w_data;
        w_strb_r <= w_strb;
      end
      if (commit_s) begin
        b_valid <= 1'b1;
        b_resp  <= w_ok_s ? 2'b00 : 2'b10;
        if (w_ok_s) begin
          wr_pulse_o <= wsel_s;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_ok_s && wsel_s[i]) begin
            regs_r[i] <= strb_merge(regs_r[i], w_data_r, w_strb_r);
          end
        end
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Read channel: registered response held until r_ready
  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= 2'b00;
    end else if (ar_hs_s) begin
      r_valid <= 1'b1;
      r_data  <= rdata_s;
      r_resp  <= r_ok_s ? 2'b00 : 2'b10;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_r[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (8 x 32-bit, register 0 read-only).
module tb_axi_lite_regfile;

  localparam logic [31:0] RST_V = 32'h0000_5A5A;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [5:0]   aw_addr, ar_addr;
  logic         aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0]  w_data, r_data;
  logic [3:0]   w_strb;
  logic [1:0]   b_resp, r_resp;
  logic         ar_valid, ar_ready, r_valid, r_ready;
  logic [255:0] ro_data_i, regs_o;
  logic [7:0]   wr_pulse_o;

  logic [31:0]  exp_r [8];
  int           tests_run = 0;
  int           tests_failed = 0;

  axi_lite_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8),
    .RO_MASK(8'h01), .RESET_VALUE(RST_V)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .ro_data_i(ro_data_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_exp();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = exp_r[i];
    return v;
  endfunction

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  task automatic reset_model();
    exp_r[0] = 32'h0;
    for (int i = 1; i < 8; i++) exp_r[i] = RST_V;
  endtask

  // AW+W together with b_ready high; checks two-edge latency, response and pulse
  task automatic wr_both(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] er, input logic [7:0] ep);
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_bvalid_early", b_valid, 1'b0);
    tick();
    chk("wr_bvalid", b_valid, 1'b1);
    chk("wr_bresp", b_resp, er);
    chk("wr_pulse", wr_pulse_o, ep);
    chk("wr_regs", regs_o, pack_exp());
    tick();
    chk("wr_bclr", b_valid, 1'b0);
    chk("wr_pulse_clr", wr_pulse_o, 8'h00);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er);
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0;
    chk("rd_rvalid", r_valid, 1'b1);
    chk("rd_ar_ready", ar_ready, 1'b0);
    tick();
    chk("rd_rdata", r_data, ed);
    chk("rd_rresp", r_resp, er);
    chk("rd_hold", r_valid, 1'b1);
    r_ready = 1'b1;
    tick();
    chk("rd_rclr", r_valid, 1'b0);
    r_ready = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b1;
    aw_addr = 6'h0; ar_addr = 6'h0; aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    w_data = 32'h0; w_strb = 4'h0; b_ready = 1'b0; r_ready = 1'b0;
    ro_data_i = '1;
    ro_data_i[31:0]  = 32'hCAFE_0001;
    ro_data_i[63:32] = 32'hBAD0_0001;
    reset_model();
    #1;
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_pulse", wr_pulse_o, 8'h00);
    chk("rst_regs", regs_o, pack_exp());
    #21 rstn_i = 1'b0;
    tick();
    chk("rel_aw_ready", aw_ready, 1'b1);
    chk("rel_w_ready", w_ready, 1'b1);
    chk("rel_ar_ready", ar_ready, 1'b1);

    // basic write then read back
    exp_r[1] = 32'hDEAD_BEEF;
    wr_both(6'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'h02);
    rd(6'h04, 32'hDEAD_BEEF, 2'b00);

    // W three cycles ahead of AW, single-byte strobe
    exp_r[1] = 32'h1122_3344;
    wr_both(6'h04, 32'h1122_3344, 4'hF, 2'b00, 8'h02);
    w_data = 32'h0000_00AA; w_strb = 4'h1; w_valid = 1'b1; b_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    chk("wfirst_w_ready", w_ready, 1'b0);
    chk("wfirst_aw_ready", aw_ready, 1'b1);
    tick(); tick(); tick();
    chk("wfirst_no_b", b_valid, 1'b0);
    aw_addr = 6'h04; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    chk("wfirst_b_early", b_valid, 1'b0);
    tick();
    exp_r[1] = 32'h1122_33AA;
    chk("wfirst_bvalid", b_valid, 1'b1);
    chk("wfirst_bresp", b_resp, 2'b00);
    chk("wfirst_reg1", reg_of(1), 32'h1122_33AA);
    chk("wfirst_pulse", wr_pulse_o, 8'h02);
    tick();
    chk("wfirst_single_b", b_valid, 1'b0);

    // out of range and read-only
    wr_both(6'h3C, 32'h1234_5678, 4'hF, 2'b10, 8'h00);
    rd(6'h3C, 32'h0, 2'b10);
    wr_both(6'h00, 32'h1234_5678, 4'hF, 2'b10, 8'h00);
    rd(6'h00, 32'hCAFE_0001, 2'b00);
    rd(6'h07, 32'h1122_33AA, 2'b00);

    // back-pressure on B with a second complete pair held
    b_ready = 1'b0;
    aw_addr = 6'h08; w_data = 32'h0102_0304; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    tick();
    exp_r[2] = 32'h0102_0304;
    chk("bp_first_b", b_valid, 1'b1);
    chk("bp_first_pulse", wr_pulse_o, 8'h04);
    aw_addr = 6'h0C; w_data = 32'hA5A5_A5A5; aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_aw_ready", aw_ready, 1'b0);
      chk("bp_w_ready", w_ready, 1'b0);
      chk("bp_b_held", b_valid, 1'b1);
      chk("bp_reg3", reg_of(3), RST_V);
      if (c < 4) tick();
    end
    b_ready = 1'b1;
    tick();
    exp_r[3] = 32'hA5A5_A5A5;
    chk("bp_second_b", b_valid, 1'b1);
    chk("bp_second_resp", b_resp, 2'b00);
    chk("bp_second_pulse", wr_pulse_o, 8'h08);
    chk("bp_regs", regs_o, pack_exp());
    tick();
    chk("bp_bclr", b_valid, 1'b0);

    // read and commit to the same register on the same edge
    aw_addr = 6'h08; w_data = 32'h0000_0055; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_addr = 6'h08; ar_valid = 1'b1; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0;
    exp_r[2] = 32'h0000_0055;
    chk("rw_same_rdata", r_data, 32'h0102_0304);
    chk("rw_same_reg2", reg_of(2), 32'h0000_0055);
    chk("rw_same_b", b_valid, 1'b1);
    r_ready = 1'b1;
    tick();
    chk("rw_same_rclr", r_valid, 1'b0);
    r_ready = 1'b0;

    // reset while a read response and a held AW are outstanding
    ar_addr = 6'h04; ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    aw_addr = 6'h04; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0;
    chk("mid_rvalid", r_valid, 1'b1);
    chk("mid_aw_held", aw_ready, 1'b0);
    #2 rstn_i = 1'b1;
    #1;
    reset_model();
    chk("mid_rst_rvalid", r_valid, 1'b0);
    chk("mid_rst_bvalid", b_valid, 1'b0);
    chk("mid_rst_regs", regs_o, pack_exp());
    #3 rstn_i = 1'b0;
    tick();
    chk("mid_rel_aw_ready", aw_ready, 1'b1);
    w_data = 32'h0000_0077; w_strb = 4'hF; w_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    tick(); tick();
    chk("mid_no_stale_b", b_valid, 1'b0);
    chk("mid_no_stale_r", r_valid, 1'b0);
    chk("mid_regs_kept", regs_o, pack_exp());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
